// File: rtl/cpu_0_jtag_cmd_pkg.sv
// Shared defaults and the pending-command record for the JTAG command synchronizer.
package cpu_0_jtag_cmd_pkg;

    localparam int SR_W_DEF        = 38;
    localparam int IR_W_DEF        = 2;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int ACT_BIT_DEF     = 34;
    localparam int FIFO_DEPTH_DEF  = 4;

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] sr;
    } cmd_entry_t;

endpackage

// File: rtl/cpu_0_jtag_sync_edge.sv
// Level synchronizer with a rising-edge strobe that only arms after a genuine
// post-reset low has been seen at the synchronizer output.
module cpu_0_jtag_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic strobe_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] vld_q;
    logic              prev_q;
    logic              armed_q;
    logic              sync_out;

    assign sync_out = sync_q[STAGES-1];

    // vld_q tracks when the chain holds real samples rather than reset zeros,
    // so a level held high through reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q  <= '0;
            vld_q   <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            vld_q  <= {vld_q[STAGES-2:0], 1'b1};
            prev_q <= sync_out;
            if (vld_q[STAGES-1] && !sync_out) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign strobe_o = armed_q & sync_out & ~prev_q;

endmodule

// File: rtl/cpu_0_jtag_cmd_sync.sv
// Moves JTAG update-DR/update-IR events into clk, queues DR commands and issues
// them as one-cycle per-channel action/no-action pulses with the captured data.
module cpu_0_jtag_cmd_sync
    import cpu_0_jtag_cmd_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            vs_udr,
    input  logic                            vs_uir,
    input  logic [IR_W-1:0]                 ir_in,
    input  logic [SR_W-1:0]                 sr,
    input  logic                            busy,
    input  logic [2**IR_W-1:0]              cmd_en,
    input  logic                            clr_ovf,
    output logic [SR_W-1:0]                 jdo,
    output logic [IR_W-1:0]                 ir_latched,
    output logic [2**IR_W-1:0]              take_action,
    output logic [2**IR_W-1:0]              take_no_action,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            overflow
);

    localparam int N_CMD = 2**IR_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Same field layout as cmd_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [IR_W-1:0] ir;
        logic [SR_W-1:0] sr;
    } entry_t;

    logic             udr_stb, uir_stb;
    entry_t           mem_q [FIFO_DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [SR_W-1:0]  jdo_q, jdo_d;
    logic [IR_W-1:0]  ir_lat_q, ir_lat_d;
    logic [N_CMD-1:0] act_q, act_d, noact_q, noact_d;
    logic             full, push, pop, wr_en;

    cpu_0_jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_udr (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_i  (vs_udr),
        .strobe_o (udr_stb)
    );

    cpu_0_jtag_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_uir (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_i  (vs_uir),
        .strobe_o (uir_stb)
    );

    always_comb begin
        full     = (cnt_q == CNT_W'(FIFO_DEPTH));
        pop      = (cnt_q != '0) && !busy;
        push     = udr_stb;
        // A pop frees the head slot this cycle, so a push into a full FIFO still lands.
        wr_en    = push && (!full || pop);
        head     = mem_q[rd_ptr_q];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        jdo_d    = jdo_q;
        ir_lat_d = ir_lat_q;
        act_d    = '0;
        noact_d  = '0;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (cmd_en[head.ir]) begin
                jdo_d = head.sr;
                if (head.sr[ACT_BIT]) begin
                    act_d = N_CMD'(1) << head.ir;
                end else begin
                    noact_d = N_CMD'(1) << head.ir;
                end
            end
        end

        case ({wr_en, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end

        if (uir_stb) begin
            ir_lat_d = ir_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            jdo_q    <= '0;
            ir_lat_q <= '0;
            act_q    <= '0;
            noact_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            jdo_q    <= jdo_d;
            ir_lat_q <= ir_lat_d;
            act_q    <= act_d;
            noact_q  <= noact_d;
        end
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= '{ir: ir_in, sr: sr};
        end
    end

    assign jdo            = jdo_q;
    assign ir_latched     = ir_lat_q;
    assign take_action    = act_q;
    assign take_no_action = noact_q;
    assign fifo_level     = cnt_q;
    assign overflow       = ovf_q;

endmodule

// File: tb/tb_cpu_0_jtag_cmd_sync.sv
// Scoreboard bench: issued commands queue their expected pulse/jdo, a monitor
// thread pops and compares on every pulse the design presents.
module tb_cpu_0_jtag_cmd_sync;
    import cpu_0_jtag_cmd_pkg::*;

    localparam int S = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset_n, vs_udr, vs_uir, busy, clr_ovf;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic [3:0]  cmd_en;
    logic [37:0] jdo;
    logic [1:0]  ir_latched;
    logic [3:0]  take_action, take_no_action;
    logic [2:0]  fifo_level;
    logic        overflow;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    cmd_entry_t exp_q[$];

    cpu_0_jtag_cmd_sync dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_udr         (vs_udr),
        .vs_uir         (vs_uir),
        .ir_in          (ir_in),
        .sr             (sr),
        .busy           (busy),
        .cmd_en         (cmd_en),
        .clr_ovf        (clr_ovf),
        .jdo            (jdo),
        .ir_latched     (ir_latched),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_udr(logic [1:0] ir, logic [37:0] v);
        ir_in  = ir;
        sr     = v;
        vs_udr = 1'b1;
        tick(3);
        vs_udr = 1'b0;
        tick(4);
    endtask

    // Model: an enabled command yields exactly one pulse on its channel, in order.
    task automatic issue(logic [1:0] ir, logic [37:0] v);
        if (cmd_en[ir]) exp_q.push_back('{ir: ir, sr: v});
        send_udr(ir, v);
    endtask

    initial begin
        cmd_entry_t  e;
        logic [3:0]  ea, en;
        logic [63:0] r64;
        int          n;

        fork
            forever begin
                @(negedge clk);
                if (take_action != 4'b0 || take_no_action != 4'b0) begin
                    pulse_cnt++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_pulse: act %b noact %b jdo %0h, required no pulse",
                                 take_action, take_no_action, jdo);
                    end else begin
                        e  = exp_q.pop_front();
                        ea = e.sr[34] ? (4'b0001 << e.ir) : 4'b0000;
                        en = e.sr[34] ? 4'b0000 : (4'b0001 << e.ir);
                        if (take_action !== ea || take_no_action !== en || jdo !== e.sr) begin
                            errors++;
                            $display("FAIL issue: act %b noact %b jdo %0h, required act %b noact %b jdo %0h",
                                     take_action, take_no_action, jdo, ea, en, e.sr);
                        end
                    end
                end
            end
        join_none

        reset_n = 1'b0; vs_udr = 1'b0; vs_uir = 1'b0; busy = 1'b0; clr_ovf = 1'b0;
        ir_in = 2'd0; sr = '0; cmd_en = 4'hF;
        tick(4);
        chk("rst_jdo",      64'(jdo), 64'(0));
        chk("rst_level",    64'(fifo_level), 64'(0));
        chk("rst_ovf",      64'(overflow), 64'(0));
        chk("rst_irlat",    64'(ir_latched), 64'(0));
        chk("rst_pulses",   64'({take_action, take_no_action}), 64'(0));
        reset_n = 1'b1;
        tick(6);

        // Single action command with exact latency
        exp_q.push_back('{ir: 2'd2, sr: 38'h04_0000_1234});
        ir_in = 2'd2; sr = 38'h04_0000_1234; vs_udr = 1'b1;
        tick(S + 1);
        chk("lat_early",    64'(take_action), 64'(0));
        tick(1);
        chk("lat_act",      64'(take_action), 64'(4'b0100));
        chk("lat_jdo",      64'(jdo), 64'(38'h04_0000_1234));
        tick(1);
        chk("lat_oneshot",  64'(take_action), 64'(0));
        vs_udr = 1'b0;
        tick(4);

        // No-action command
        issue(2'd1, 38'h00_0000_5678);
        tick(2);
        chk("noact_count",  64'(pulse_cnt), 64'(2));

        // Backpressure and overflow: only the first D entries survive
        busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i <= D) exp_q.push_back('{ir: 2'd2, sr: 38'(i)});
            send_udr(2'd2, 38'(i));
        end
        chk("bp_level",     64'(fifo_level), 64'(4));
        chk("bp_ovf",       64'(overflow), 64'(1));
        busy = 1'b0;
        tick(5);
        chk("bp_pops",      64'(pulse_cnt), 64'(6));
        chk("bp_empty",     64'(fifo_level), 64'(0));
        chk("bp_ovf_hold",  64'(overflow), 64'(1));
        clr_ovf = 1'b1;
        tick(1);
        clr_ovf = 1'b0;
        chk("ovf_clr",      64'(overflow), 64'(0));

        // Disabled channel discards, enabled one issues
        cmd_en = 4'b1110;
        issue(2'd0, 38'h03_dead_beef);
        tick(2);
        chk("dis_jdo",      64'(jdo), 64'(38'd4));
        chk("dis_count",    64'(pulse_cnt), 64'(6));
        issue(2'd3, 38'h04_0000_00aa);
        tick(2);
        chk("en_count",     64'(pulse_cnt), 64'(7));
        chk("en_jdo",       64'(jdo), 64'(38'h04_0000_00aa));

        // IR path
        ir_in = 2'd3; vs_uir = 1'b1;
        tick(S);
        chk("ir_early",     64'(ir_latched), 64'(0));
        tick(1);
        chk("ir_latch3",    64'(ir_latched), 64'(3));
        chk("ir_fifo",      64'(fifo_level), 64'(0));
        vs_uir = 1'b0;
        tick(4);
        ir_in = 2'd1; vs_uir = 1'b1;
        tick(S + 1);
        chk("ir_latch1",    64'(ir_latched), 64'(1));
        vs_uir = 1'b0;
        tick(4);
        chk("ir_nopulse",   64'(pulse_cnt), 64'(7));

        // Update-DR held high through reset release
        cmd_en = 4'hF;
        ir_in = 2'd2; sr = 38'h04_0000_0001; vs_udr = 1'b1;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(12);
        vs_udr = 1'b0;
        tick(6);
        chk("hold_nopulse", 64'(pulse_cnt), 64'(7));
        chk("hold_level",   64'(fifo_level), 64'(0));

        // Reset with queued entries
        busy = 1'b1;
        for (int i = 0; i < 3; i++) send_udr(2'd1, 38'(i + 9));
        chk("q_level",      64'(fifo_level), 64'(3));
        reset_n = 1'b0;
        tick(2);
        chk("q_rst_level",  64'(fifo_level), 64'(0));
        reset_n = 1'b1;
        busy = 1'b0;
        tick(20);
        chk("q_nopulse",    64'(pulse_cnt), 64'(7));
        chk("q_rst_jdo",    64'(jdo), 64'(0));

        // Randomized bursts with random stalls
        for (int b = 0; b < 10; b++) begin
            cmd_en = 4'($urandom_range(0, 15));
            n = $urandom_range(1, D);
            for (int k = 0; k < n; k++) begin
                busy = 1'($urandom_range(0, 1));
                r64 = {$urandom(), $urandom()};
                issue(2'($urandom_range(0, 3)), r64[37:0]);
            end
            busy = 1'b0;
            for (int c = 0; c < 60 && !(fifo_level == 3'd0 && exp_q.size() == 0); c++) tick(1);
            tick(2);
            chk("rnd_drain",    64'(exp_q.size()), 64'(0));
            chk("rnd_level",    64'(fifo_level), 64'(0));
            chk("rnd_ovf",      64'(overflow), 64'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
